// File: rtl/vertex_pe_mac.sv
// GNN combination-phase vertex PE: NUM_MULT-wide multiply, adder-tree reduce, per-node accumulate.
// Optional output ReLU is enabled by defining VERTEX_PE_RELU_EN.

module vertex_pe_lane #(
  parameter int FV_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [FV_W-1:0] w,
  input  logic [FV_W-1:0] fv,
  output logic [FV_W-1:0] prod
);
  // Product is deliberately evaluated at FV_W bits: the upper half is discarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  prod <= '0;
    else if (en) prod <= w * fv;
  end
endmodule

module vertex_pe_mac #(
  parameter int NUM_MULT = 4,
  parameter int FV_W     = 16,
  parameter int NODE_W   = 10,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_MULT*FV_W-1:0] weight_in,
  input  logic [NUM_MULT*FV_W-1:0] fv_in,
  input  logic [NODE_W-1:0]        node_id_in,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FV_W-1:0]          vertex_out,
  output logic [NODE_W-1:0]        node_id_out,
  output logic [CNT_W-1:0]         nodes_done
);
  localparam int LG = $clog2(NUM_MULT);

  typedef struct packed {
    logic [NODE_W-1:0] id;
    logic              last;
  } s1_meta_t;

  logic                          stall, xfer;
  logic [NUM_MULT-1:0][FV_W-1:0] prod;
  s1_meta_t                      s1_meta;
  logic                          s1_valid;
  logic [FV_W-1:0]               acc, sum, total, result;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign xfer     = in_valid & in_ready;

  // S1: one multiplier lane per weight/feature pair
  for (genvar i = 0; i < NUM_MULT; i++) begin : g_lane
    vertex_pe_lane #(.FV_W(FV_W)) u_lane (
      .clk  (clk),
      .reset(reset),
      .en   (xfer),
      .w    (weight_in[i*FV_W +: FV_W]),
      .fv   (fv_in[i*FV_W +: FV_W]),
      .prod (prod[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_meta  <= '0;
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= xfer;
      if (xfer) s1_meta <= '{id: node_id_in, last: in_last};
    end
  end

  // Binary adder tree; each level is its own signal so no level feeds back on itself.
  for (genvar l = 0; l <= LG; l++) begin : g_lvl
    logic [(NUM_MULT>>l)-1:0][FV_W-1:0] s;
    if (l == 0) begin : g_leaf
      assign s = prod;
    end else begin : g_node
      for (genvar j = 0; j < (NUM_MULT>>l); j++) begin : g_add
        assign s[j] = g_lvl[l-1].s[2*j] + g_lvl[l-1].s[2*j+1];
      end
    end
  end

  assign sum   = g_lvl[LG].s[0];
  assign total = acc + sum;

`ifdef VERTEX_PE_RELU_EN
  assign result = total[FV_W-1] ? '0 : total;
`else
  assign result = total;
`endif

  // S2: accumulate, or close the node and publish the result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc         <= '0;
      vertex_out  <= '0;
      node_id_out <= '0;
      out_valid   <= 1'b0;
    end else if (!stall) begin
      // Not stalled means any held result is being taken this cycle.
      out_valid <= s1_valid & s1_meta.last;
      if (s1_valid) begin
        if (s1_meta.last) begin
          vertex_out  <= result;
          node_id_out <= s1_meta.id;
          acc         <= '0;
        end else begin
          acc <= total;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      nodes_done <= '0;
    else if (out_valid && out_ready) nodes_done <= nodes_done + 1'b1;
  end
endmodule

// File: doc/vertex_pe_mac.md
Name: vertex_pe_mac

Overview:
Parametrised vertex processing element for the GNN combination phase.
- Multiplies NUM_MULT weight/feature-element pairs per beat and reduces them through an adder tree.
- Accumulates the reduced sums over a multi-beat dot product, one beat group per node.
- Emits one tagged result per node.
- Sits between the feature/weight buffers and the output writeback, with valid/ready on both sides.

Parameters:
- NUM_MULT, 4, multipliers per PE (power of 2, >=2).
- FV_W, 16, feature/weight element width, unsigned.
- NODE_W, 10, node-id width.
- CNT_W, 16, width of the completed-node counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- in_valid  in  1  beat valid
- in_ready  out  1  PE can accept a beat this cycle
- weight_in  in  NUM_MULT*FV_W  packed weights; lane i at bits [i*FV_W +: FV_W]
- fv_in  in  NUM_MULT*FV_W  packed feature elements, same lane packing
- node_id_in  in  NODE_W  node id of this beat
- in_last  in  1  final beat of this node's dot product
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- vertex_out  out  FV_W  dot-product result
- node_id_out  out  NODE_W  node id of result
- nodes_done  out  CNT_W  count of results accepted downstream

Behaviour:
- Reset (reset=0, async): all of the following cleared immediately:
  - out_valid=0, vertex_out=0, node_id_out=0, nodes_done=0.
  - Accumulator=0, stage-1 valid=0.
  - in_ready is 1 right after reset.
- Arithmetic: unsigned.
  - Each product is truncated to FV_W bits.
  - Adder-tree sum and accumulation wrap modulo 2^FV_W; no saturation.
- Stall: stall = out_valid & ~out_ready. in_ready = ~stall.
  - While stalled, the S1 and S2 registers and the accumulator hold their values.
- Beat transfer: in_valid & in_ready.
- S1 (registered):
  - On a transfer, register the NUM_MULT truncated products, node_id_in and in_last, and set s1_valid=1.
  - Without a transfer (and not stalled), s1_valid<=0.
- S2 (registered, only when s1_valid & ~stall):
  - sum = adder-tree total of the S1 products.
  - s1_last=0: acc<=acc+sum.
  - s1_last=1: vertex_out<=acc+sum, node_id_out<=S1 id, out_valid<=1, acc<=0.
- Latency: a last beat transferred in cycle t gives out_valid=1 in cycle t+2 with no stall. Throughput is 1 beat/cycle.
- Output handshake:
  - out_valid & out_ready: nodes_done<=nodes_done+1, wrapping at 2^CNT_W.
  - out_valid clears unless a new result is loaded in the same cycle. Back-to-back results are allowed.
  - vertex_out and node_id_out are stable while out_valid=1 and out_ready=0.
- Single-beat node (in_last on its first beat): result = sum of that beat; the accumulator is 0 by construction.
- Node id: the result carries the id of the last beat. Ids of non-last beats are ignored.
- Reset mid-node: the partial accumulation is discarded and the next beat starts a fresh node.
- in_valid=0 between beats of the same node is allowed; the accumulator is preserved.

Optional Feature:
- Macro: VERTEX_PE_RELU_EN.
- Defined: the result is treated as signed two's-complement at the output stage. If bit FV_W-1 of acc+sum is 1, vertex_out is loaded with 0. The accumulator path is unchanged.
- Undefined: vertex_out = acc+sum unmodified. No extra logic.

Test Plan:
1. NUM_MULT=4, FV_W=16. Single beat, last=1, id=7, w={1,2,3,4}, fv={5,6,7,8}, out_ready=1 -> two cycles later out_valid=1, vertex_out=70, node_id_out=7, nodes_done becomes 1.
2. Two-beat node, id=3:
   - Beat 1: w={1,1,1,1}, fv={10,20,30,40}.
   - Beat 2 (last): w={2,2,2,2}, fv={1,1,1,1}.
   - Required: vertex_out=108, node_id_out=3. A following single-beat node with sum=5 outputs 5 (accumulator cleared).
3. Backpressure: result pending with out_ready=0 for 4 cycles while in_valid=1 -> in_ready=0 throughout, vertex_out held. When out_ready=1, streaming resumes with no beat lost or duplicated.
4. Wrap: w={0x8000,0x8000,0,0}, fv={2,1,0,0}, last=1 -> product0 truncates to 0x0000, vertex_out=0x8000 (without RELU) or 0 (with VERTEX_PE_RELU_EN).
5. Assert reset=0 after the first beat of a 3-beat node, then send a single last beat with sum=9 -> vertex_out=9, nodes_done=1 counted from 0.
6. Continuous single-beat nodes, ids 0..15, with out_ready=1 -> 16 results on consecutive cycles in order, nodes_done=16.
